count_monitor: RTL and testbench
================================

# count_monitor

Downstream checker for the 4-bit free-running up-counter. It samples the counter value each valid cycle and verifies that every step is +1 modulo 2^WIDTH. It declares lock after a run of good steps and then counts wrap-arounds, stalls and step errors. Status outputs feed the debug/readout logic and the bench scoreboard.

## Interface
Parameters:
- WIDTH, 4, width of the monitored count.
- LOCK_LEN, 4, consecutive good (+1) steps required to enter LOCKED; legal range 1..15.
- WRAP_W, 8, width of the wrap and error counters.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; same effect as rst, applied on the edge.
- cnt_in  in  WIDTH  counter value under observation.
- cnt_vld  in  1  cnt_in is sampled only on edges where cnt_vld=1.
- locked  out  1  high while in LOCKED.
- step_err  out  1  one-cycle pulse on a bad step while LOCKED.
- hold_pulse  out  1  one-cycle pulse when a valid sample equals the previous one.
- wrap_cnt  out  WRAP_W  saturating count of observed max→0 transitions.
- err_cnt  out  WRAP_W  saturating count of step_err events.

## Operation
- All outputs are registered. Reset and clr values:
  - state=IDLE, prev=0, run=0.
  - locked=0, step_err=0, hold_pulse=0, wrap_cnt=0, err_cnt=0.
- delta = (cnt_in − prev) mod 2^WIDTH, computed at WIDTH bits. Classes:
  - GOOD: delta=1.
  - HOLD: delta=0.
  - BAD: any other value.
- States:
  - IDLE: no reference sample. The first valid sample loads prev, sets run=0 and moves to SEARCH. It generates no pulses and no counts.
  - SEARCH:
    - GOOD: run+1; when run reaches LOCK_LEN, go to LOCKED.
    - HOLD: run unchanged.
    - BAD: run=0, state stays SEARCH, no step_err.
  - LOCKED:
    - GOOD: stay.
    - HOLD: stay; hold_pulse=1.
    - BAD: step_err=1, err_cnt+1, run=0, go to SEARCH.
- A wrap is a GOOD step with prev=2^WIDTH−1 and cnt_in=0. Wraps increment wrap_cnt in SEARCH and LOCKED.
- hold_pulse is asserted on HOLD in both SEARCH and LOCKED.
- prev is updated on every valid sample in every state.
- Counters saturate at 2^WRAP_W−1 and never roll over.
- cnt_vld=0: the edge is ignored entirely. State, prev and run hold; pulses deassert.
- Simultaneous events:
  - clr has priority over a valid sample on the same edge.
  - rst overrides everything, asynchronously.

## Timing
- Sample accepted on edge N. locked, step_err, hold_pulse and the counters reflect it after edge N (visible during cycle N+1). Latency is 1 cycle.
- Lock time from IDLE with back-to-back good samples: the first sample plus LOCK_LEN good steps. locked rises after edge LOCK_LEN+1 counted from the first valid sample.
- Pulses last exactly one cycle. A pulse is not stretched if cnt_vld drops.
- rst asserted mid-operation:
  - All outputs clear immediately, without waiting for clk.
  - After deassertion, the next valid sample is treated as the IDLE reference.
- An upstream counter reset (e.g. 9→0) is BAD. While LOCKED it produces one step_err and drops lock.

## Structure
- Package count_mon_pkg holds:
  - the state enum (IDLE, SEARCH, LOCKED);
  - the delta class enum (GOOD, HOLD, BAD);
  - a classify function of (prev, cnt_in).
- Sub-module sat_counter (parameter W; inputs inc and clr; output q): saturating counter, instantiated for wrap_cnt and err_cnt.
- The top holds the FSM, the prev and run registers, and the pulse registers.

## Test plan
- Reset/lock:
  - Stimulus: rst high, then release; feed 0,1,2,3,4 with cnt_vld=1 every cycle.
  - Required: all outputs 0 during reset; locked=1 after the sample 4 edge; no pulses.
- Wrap:
  - Stimulus: locked, feed 13,14,15,0,1.
  - Required: wrap_cnt 0→1 one cycle after the 0 sample; locked stays 1.
- Step error:
  - Stimulus: locked at 6, feed 9.
  - Required: step_err for one cycle, err_cnt=1, locked=0.
  - Then: 10,11,12,13 → locked=1 again.
- Hold/gaps:
  - Stimulus: locked at 5, feed 5, then cnt_vld=0 for 3 cycles, then 6.
  - Required: hold_pulse once, no step_err, locked stays 1.
- Saturation/clr:
  - Stimulus: WRAP_W=2, force 5 step errors.
  - Required: err_cnt sticks at 3.
  - Then: clr for one cycle together with a valid sample → all outputs 0, state IDLE.
- Async reset mid-run:
  - Stimulus: rst pulse between edges while LOCKED with wrap_cnt=2.
  - Required: locked and wrap_cnt drop to 0 before the next clk edge.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types and step classification for the counter monitor.
package count_mon_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StLocked = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DeltaGood = 2'd0,
    DeltaHold = 2'd1,
    DeltaBad  = 2'd2
  } delta_e;

  // Step delta is taken modulo 2^width so that max->0 classifies as a +1 step.
  function automatic delta_e classify(input logic [31:0] prev, input logic [31:0] cnt,
                                      input int unsigned width);
    logic [31:0] mask;
    logic [31:0] delta;
    mask  = (32'd1 << width) - 32'd1;
    delta = (cnt - prev) & mask;
    if (delta == 32'd1) return DeltaGood;
    if (delta == 32'd0) return DeltaHold;
    return DeltaBad;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/count_monitor.sv
// Checks that a sampled counter advances by +1 per valid sample; tracks lock, wraps and errors.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_vld,
  output logic              locked,
  output logic              step_err,
  output logic              hold_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [WRAP_W-1:0] err_cnt
);

  localparam logic [WIDTH-1:0] CntMax  = {WIDTH{1'b1}};
  localparam logic [3:0]       LockLen = 4'(LOCK_LEN);

  state_e           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_run;
  logic             r_locked;
  logic             r_step_err;
  logic             r_hold_pulse;

  delta_e           w_class;
  logic [3:0]       w_run_inc;
  logic             w_wrap_inc;
  logic             w_err_inc;

  assign w_class   = classify(32'(r_prev), 32'(cnt_in), WIDTH);
  assign w_run_inc = r_run + 4'd1;

  // Counter events are only meaningful once a reference sample exists.
  assign w_wrap_inc = cnt_vld && (r_state != StIdle) && (r_prev == CntMax) &&
                      (cnt_in == '0);
  assign w_err_inc  = cnt_vld && (r_state == StLocked) && (w_class == DeltaBad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_prev       <= '0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_step_err   <= 1'b0;
      r_hold_pulse <= 1'b0;
    end else if (clr) begin
      r_state      <= StIdle;
      r_prev       <= '0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_step_err   <= 1'b0;
      r_hold_pulse <= 1'b0;
    end else begin
      r_step_err   <= 1'b0;
      r_hold_pulse <= 1'b0;
      if (cnt_vld) begin
        r_prev <= cnt_in;
        case (r_state)
          StIdle: begin
            r_run   <= '0;
            r_state <= StSearch;
          end
          StSearch: begin
            unique case (w_class)
              DeltaGood: begin
                r_run <= w_run_inc;
                if (w_run_inc == LockLen) begin
                  r_state  <= StLocked;
                  r_locked <= 1'b1;
                end
              end
              DeltaHold: r_hold_pulse <= 1'b1;
              default:   r_run        <= '0;
            endcase
          end
          StLocked: begin
            unique case (w_class)
              DeltaGood: ;
              DeltaHold: r_hold_pulse <= 1'b1;
              default: begin
                r_step_err <= 1'b1;
                r_run      <= '0;
                r_state    <= StSearch;
                r_locked   <= 1'b0;
              end
            endcase
          end
          default: begin
            r_state  <= StIdle;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W (WRAP_W)
  ) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_wrap_inc),
    .q   (wrap_cnt)
  );

  sat_counter #(
    .W (WRAP_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_err_inc),
    .q   (err_cnt)
  );

  assign locked     = r_locked;
  assign step_err   = r_step_err;
  assign hold_pulse = r_hold_pulse;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: lock, wrap, step error, hold/gaps, saturation, async reset.
module tb_count_monitor;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [3:0] cnt_in;
  logic       cnt_vld;

  logic       locked, step_err, hold_pulse;
  logic [7:0] wrap_cnt, err_cnt;

  logic       s_locked, s_step_err, s_hold_pulse;
  logic [1:0] s_wrap_cnt, s_err_cnt;

  int errors = 0;
  int checks = 0;

  count_monitor #(
    .WIDTH    (4),
    .LOCK_LEN (4),
    .WRAP_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .cnt_in     (cnt_in),
    .cnt_vld    (cnt_vld),
    .locked     (locked),
    .step_err   (step_err),
    .hold_pulse (hold_pulse),
    .wrap_cnt   (wrap_cnt),
    .err_cnt    (err_cnt)
  );

  // Small instance for saturation: 2-bit counters, lock after a single good step.
  count_monitor #(
    .WIDTH    (4),
    .LOCK_LEN (1),
    .WRAP_W   (2)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .cnt_in     (cnt_in),
    .cnt_vld    (cnt_vld),
    .locked     (s_locked),
    .step_err   (s_step_err),
    .hold_pulse (s_hold_pulse),
    .wrap_cnt   (s_wrap_cnt),
    .err_cnt    (s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic feed(input logic [3:0] v, input logic vld);
    cnt_in  = v;
    cnt_vld = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; cnt_in = 4'd0; cnt_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err got=%b exp=0", step_err); end
    checks++; if (hold_pulse !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", hold_pulse); end
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap got=%0d exp=0", wrap_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      feed(4'(i), 1'b1);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early s=%0d got=%b exp=0", i, locked); end
    end
    feed(4'd4, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after4 got=%b exp=1", locked); end
    checks++; if ({step_err, hold_pulse} !== 2'b00) begin
      errors++; $display("FAIL lock_pulses got=%b exp=00", {step_err, hold_pulse});
    end
  endtask

  task automatic test_wrap;
    for (int v = 5; v <= 15; v++) feed(4'(v), 1'b1);
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL wrap_pre got=%0d exp=0", wrap_cnt); end
    feed(4'd0, 1'b1);
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL wrap_inc got=%0d exp=1", wrap_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got=%b exp=1", locked); end
    feed(4'd1, 1'b1);
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL wrap_hold got=%0d exp=1", wrap_cnt); end
  endtask

  task automatic test_step_err;
    for (int v = 2; v <= 6; v++) feed(4'(v), 1'b1);
    feed(4'd9, 1'b1);
    checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL step_err_pulse got=%b exp=1", step_err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL step_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL step_err_unlock got=%b exp=0", locked); end
    feed(4'd10, 1'b1);
    checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL step_err_len got=%b exp=0", step_err); end
    feed(4'd11, 1'b1);
    feed(4'd12, 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got=%b exp=0", locked); end
    feed(4'd13, 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got=%b exp=1", locked); end
  endtask

  task automatic test_hold_gap;
    feed(4'd14, 1'b1);
    feed(4'd15, 1'b1);
    for (int v = 0; v <= 5; v++) feed(4'(v), 1'b1);
    checks++; if (wrap_cnt !== 8'd2) begin errors++; $display("FAIL wrap_second got=%0d exp=2", wrap_cnt); end
    feed(4'd5, 1'b1);
    checks++; if (hold_pulse !== 1'b1) begin errors++; $display("FAIL hold_pulse got=%b exp=1", hold_pulse); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hold_locked got=%b exp=1", locked); end
    for (int i = 0; i < 3; i++) begin
      feed(4'd12, 1'b0);
      checks++; if ({hold_pulse, step_err, locked} !== 3'b001) begin
        errors++; $display("FAIL gap%0d hold/err/lock got=%b exp=001", i, {hold_pulse, step_err, locked});
      end
    end
    feed(4'd6, 1'b1);
    checks++; if ({hold_pulse, step_err, locked} !== 3'b001) begin
      errors++; $display("FAIL after_gap hold/err/lock got=%b exp=001", {hold_pulse, step_err, locked});
    end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL hold_err_cnt got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_async_reset;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked got=%b exp=0", locked); end
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL async_wrap got=%0d exp=0", wrap_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL async_err got=%0d exp=0", err_cnt); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    feed(4'd7, 1'b1);
    feed(4'd9, 1'b1);
    checks++; if ({step_err, err_cnt} !== 9'd0) begin
      errors++; $display("FAIL search_bad step_err/err_cnt got=%b/%0d exp=0/0", step_err, err_cnt);
    end
    for (int v = 10; v <= 13; v++) feed(4'(v), 1'b1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL post_rst_lock got=%b exp=1", locked); end
  endtask

  task automatic test_sat_clr;
    logic [3:0] v;
    #2; rst = 1'b1; #1; rst = 1'b0;
    @(posedge clk);
    #1;
    v = 4'd0;
    feed(v, 1'b1);
    v = v + 4'd1;
    feed(v, 1'b1);
    checks++; if (s_locked !== 1'b1) begin errors++; $display("FAIL sat_lock got=%b exp=1", s_locked); end
    for (int i = 0; i < 5; i++) begin
      v = v + 4'd5;
      feed(v, 1'b1);
      checks++; if (s_err_cnt !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        errors++; $display("FAIL sat_err%0d got=%0d exp=%0d", i, s_err_cnt, (i + 1 > 3) ? 3 : i + 1);
      end
      v = v + 4'd1;
      feed(v, 1'b1);
    end
    checks++; if (s_err_cnt !== 2'd3) begin errors++; $display("FAIL sat_stick got=%0d exp=3", s_err_cnt); end
    clr = 1'b1;
    v = v + 4'd1;
    feed(v, 1'b1);
    clr = 1'b0;
    checks++; if ({s_locked, s_step_err, s_hold_pulse, s_wrap_cnt, s_err_cnt} !== 7'd0) begin
      errors++; $display("FAIL clr_outputs got=%b exp=0000000",
                         {s_locked, s_step_err, s_hold_pulse, s_wrap_cnt, s_err_cnt});
    end
    v = v + 4'd1;
    feed(v, 1'b1);
    checks++; if (s_locked !== 1'b0) begin errors++; $display("FAIL clr_idle_ref got=%b exp=0", s_locked); end
    v = v + 4'd1;
    feed(v, 1'b1);
    checks++; if (s_locked !== 1'b1) begin errors++; $display("FAIL clr_relock got=%b exp=1", s_locked); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_step_err();
    test_hold_gap();
    test_async_reset();
    test_sat_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
